sobel_window: RTL and testbench
===============================

# sobel_window

Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel edge filter. It accepts one 8-bit grey pixel per valid cycle in raster order and buffers the two previous image rows in line buffers. Whenever a complete 3x3 window is available, it presents the window as nine pixels in the index order the Sobel stage consumes. There is no backpressure: the downstream filter is purely combinational and accepts every window.

## Interface
Parameters:
- IMG_WIDTH, 640, pixels per row (>= 3)
- IMG_HEIGHT, 480, rows per frame (>= 3)
- PIX_W, 8, bits per pixel

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_in  in  PIX_W  input pixel
- pix_valid  in  1  pix_in valid this cycle
- sof  in  1  start of frame; qualified by pix_valid; marks pix_in as pixel (0,0)
- win_out  out  9*PIX_W  window; slice k = Pixels[k], row-major, k=0 top-left, k=8 bottom-right
- win_valid  out  1  win_out valid this cycle
- frame_done  out  1  one-cycle pulse after last pixel of frame accepted
- win_cx, win_cy  out  16 each  centre coordinate of window (only with macro, see Configuration)

## Operation
- Accepted pixel = pix_valid high at a clk edge. pix_valid low: nothing changes; win_valid and frame_done deassert.
- Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) give the position of the accepted pixel.
  - col wraps to 0 after IMG_WIDTH-1 and row then increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and frame_done pulses.
- Two line buffers, each IMG_WIDTH deep:
  - On every accepted pixel, lb1 is read at col, giving row-1.
  - lb0 is read at col, giving row-2.
  - lb0[col] is written with lb1's read data; lb1[col] is written with pix_in (read-before-write).
- 3x3 shift register: each accepted pixel shifts the three columns left. The new right column is {lb0 out, lb1 out, pix_in} for top, middle, bottom.
- Window for accepted pixel (r,c) covers rows r-2..r and columns c-2..c. Pixels[0] = (r-2,c-2), Pixels[2] = (r-2,c), Pixels[6] = (r,c-2), Pixels[8] = (r,c).
- Emitted only when r >= 2 and c >= 2. No border padding; each frame yields exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- State machine, advancing on accepted pixels only:
  - FILL: row < 2. Line buffers priming, win_valid forced low. Transitions to ACTIVE on the first accepted pixel with row = 2.
  - ACTIVE: windows emitted per the column rule. Returns to FILL on frame wrap or on sof.
- Stale shift-register columns at row start are never emitted, because the c >= 2 rule masks them.
- sof with pix_valid at any position: that pixel is treated as (0,0), the state goes to FILL, and no frame_done pulse occurs. Old line-buffer data is never emitted.
- sof without pix_valid is ignored.

## Timing
- Latency: one cycle. The window completed by pixel (r,c) at edge N has win_valid and win_out registered at edge N and visible until edge N+1.
- win_valid is high for exactly one cycle per qualifying accepted pixel. Back-to-back pixels give back-to-back windows.
- frame_done is high the cycle after the final pixel is accepted, coincident with the last window's win_valid.
- Reset values: win_out = 0, win_valid = 0, frame_done = 0, win_cx = win_cy = 0, col = row = 0, state = FILL. Line-buffer contents are not reset.
- rst mid-frame: the next accepted pixel is (0,0).
- rst takes priority over pix_valid and sof in the same cycle.

## Configuration
- SOBEL_WINDOW_COORD_EN
  - Defined: win_cx = c-1 and win_cy = r-1 are registered alongside win_out and valid when win_valid is high. Widths are 16 bits, zero-extended.
  - Undefined: the win_cx and win_cy ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package sobel_pkg holds:
  - PIX_W default
  - the window index constants (WIN_TL=0 .. WIN_BR=8)
  - the state enum {FILL, ACTIVE}
  - the win_out packing order, which the Sobel stage also uses
- Sub-module line_buffer: DEPTH x PIX_W memory with registered write and combinational read-before-write at the same address. It is instantiated twice.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*r + c, and continuous pix_valid.
- Full frame: first win_valid is the cycle after pixel 0x22, with Pixels[0..8] = 00,01,02,10,11,12,20,21,22. The frame yields exactly 4 windows, the last ending 0x33. frame_done pulses with the last window.
- Random pix_valid gaps (1–5 idle cycles): the window sequence is identical to the continuous case, and win_valid is never high in an idle-input cycle.
- Two frames back-to-back: the second frame's first window is again 00..22 offset by frame, with no window emitted during its rows 0–1.
- sof asserted at pixel (1,2): counters restart, no frame_done pulse, and the first window appears after the new frame's (2,2) pixel, containing only new-frame data.
- rst pulsed mid-row 2: all outputs are 0 the next cycle, and the frame then restarts cleanly with 4 windows.
- With SOBEL_WINDOW_COORD_EN: the four windows report (cx,cy) = (1,1), (2,1), (1,2), (2,2).

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel path: window index map, packing helper and
// the window generator state encoding.
package sobel_pkg;

    localparam int DEF_PIX_W = 8;
    localparam int WIN_N     = 9;

    // Row-major window indices; slice k of win_out holds Pixels[k].
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    typedef enum logic {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } win_state_t;

    // LSB of window slice k inside the packed win_out bus.
    function automatic int win_lsb(input int k, input int pix_w);
        return k * pix_w;
    endfunction

endpackage

// File: rtl/sobel_window_line_buffer.sv
// One image row of pixel storage: registered write, combinational read of the
// old contents at the same address (read-before-write).
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [PIX_W-1:0]         wdata,
    output logic [PIX_W-1:0]         rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window.sv
// Streaming 3x3 window generator feeding the Sobel filter. Optional centre
// coordinate outputs win_cx/win_cy are built when SOBEL_WINDOW_COORD_EN is defined.
module sobel_window
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PIX_W-1:0]         pix_in,
    input  logic                     pix_valid,
    input  logic                     sof,
    output logic [WIN_N*PIX_W-1:0]   win_out,
    output logic                     win_valid,
    output logic                     frame_done
`ifdef SOBEL_WINDOW_COORD_EN
    ,
    output logic [15:0]              win_cx,
    output logic [15:0]              win_cy
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]          col, pos_col;
    logic [RW-1:0]          row, pos_row;
    win_state_t             state;
    logic [PIX_W-1:0]       lb0_rd, lb1_rd;
    logic [PIX_W-1:0]       sr_next [WIN_N];
    logic [WIN_N*PIX_W-1:0] win_next;
    logic                   col_last, row_last, frame_wrap, emit, accept;

    assign accept = pix_valid && !rst;

    // A sof pixel is position (0,0) no matter where the counters were.
    always_comb begin
        pos_col    = sof ? '0 : col;
        pos_row    = sof ? '0 : row;
        col_last   = (pos_col == CW'(IMG_WIDTH - 1));
        row_last   = (pos_row == RW'(IMG_HEIGHT - 1));
        frame_wrap = col_last && row_last;
        emit       = (state == ACTIVE) && !sof &&
                     (pos_row >= RW'(2)) && (pos_col >= CW'(2));
    end

    always_comb begin
        win_next = '0;
        for (int k = 0; k < WIN_N; k++) begin
            if ((k % 3) != 2) begin
                sr_next[k] = win_out[win_lsb(k + 1, PIX_W) +: PIX_W];
            end else begin
                sr_next[k] = '0;
            end
        end
        sr_next[WIN_TR] = lb0_rd;
        sr_next[WIN_MR] = lb1_rd;
        sr_next[WIN_BR] = pix_in;
        for (int k = 0; k < WIN_N; k++) begin
            win_next[win_lsb(k, PIX_W) +: PIX_W] = sr_next[k];
        end
    end

    line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (pos_col),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (pos_col),
        .wdata (pix_in),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            state      <= FILL;
            win_out    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
`ifdef SOBEL_WINDOW_COORD_EN
            win_cx     <= '0;
            win_cy     <= '0;
`endif
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                // The shift register is the output register; win_valid qualifies it.
                win_out    <= win_next;
                win_valid  <= emit;
                frame_done <= frame_wrap;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : pos_row + 1'b1;
                end else begin
                    col <= pos_col + 1'b1;
                    row <= pos_row;
                end
                case (state)
                    FILL:   if (!sof && pos_row == RW'(2)) state <= ACTIVE;
                    ACTIVE: if (sof || frame_wrap) state <= FILL;
                    default: state <= FILL;
                endcase
`ifdef SOBEL_WINDOW_COORD_EN
                if (emit) begin
                    win_cx <= 16'(pos_col) - 16'd1;
                    win_cy <= 16'(pos_row) - 16'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_sobel_window.sv
// Scoreboard bench for sobel_window on a 4x4 image; the reference model keeps
// the frame in a 2-D array and cuts expected windows straight out of it.
module tb_sobel_window;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int EW = 9 * PW + 1 + 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            pix_valid = 1'b0;
    logic            sof = 1'b0;
    logic [PW-1:0]   pix_in = '0;
    logic [9*PW-1:0] win_out;
    logic            win_valid;
    logic            frame_done;
`ifdef SOBEL_WINDOW_COORD_EN
    logic [15:0]     win_cx, win_cy;
`endif

    sobel_window #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .frame_done (frame_done)
`ifdef SOBEL_WINDOW_COORD_EN
        ,
        .win_cx     (win_cx),
        .win_cy     (win_cy)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    bit            exp_v_q[$];
    int            tests = 0;
    int            fails = 0;
    logic [PW-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;
    logic          acc_last = 1'b0;
    int            wcount = 0;

    always @(posedge clk) begin
        acc_last = pix_valid && !rst;
        if (rst) wcount = 0;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] e;
        bit            ev;
        if (!acc_last) begin
            tests++;
            if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                fails++;
                $display("FAIL idle_out: win_valid=%b frame_done=%b, required 0 0", win_valid, frame_done);
            end
        end else begin
            tests++;
            if (exp_v_q.size() == 0) begin
                fails++;
                $display("FAIL exp_sync: accepted pixel with no model entry");
                ev = 1'b0;
            end else begin
                ev = exp_v_q.pop_front();
                if (win_valid !== ev) begin
                    fails++;
                    $display("FAIL win_valid: got %b required %b", win_valid, ev);
                end
            end
            if (ev) begin
                e = exp_q.pop_front();
                if (win_valid === 1'b1) begin
                    wcount++;
                    tests++;
                    if (win_out !== e[EW-1:33]) begin
                        fails++;
                        $display("FAIL win_out: got %h required %h", win_out, e[EW-1:33]);
                    end
                    tests++;
                    if (frame_done !== e[32]) begin
                        fails++;
                        $display("FAIL frame_done: got %b required %b", frame_done, e[32]);
                    end
`ifdef SOBEL_WINDOW_COORD_EN
                    tests++;
                    if (win_cx !== e[31:16] || win_cy !== e[15:0]) begin
                        fails++;
                        $display("FAIL coord: got (%0d,%0d) required (%0d,%0d)", win_cx, win_cy, e[31:16], e[15:0]);
                    end
`endif
                    if (frame_done === 1'b1) begin
                        tests++;
                        if (wcount != (W - 2) * (H - 2)) begin
                            fails++;
                            $display("FAIL win_count: got %0d required %0d", wcount, (W - 2) * (H - 2));
                        end
                        wcount = 0;
                    end
                end
            end else begin
                tests++;
                if (frame_done !== 1'b0) begin
                    fails++;
                    $display("FAIL frame_done_nowin: got %b required 0", frame_done);
                end
            end
        end
    end

    // driver tasks; each starts and ends 1 time unit after a rising edge
    task automatic send(input logic [PW-1:0] v, input bit s);
        logic [9*PW-1:0] w;
        if (s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = v;
        if (mr >= 2 && mc >= 2) begin
            for (int k = 0; k < 9; k++) w[k*PW +: PW] = img[mr - 2 + k / 3][mc - 2 + k % 3];
            exp_q.push_back({w, 1'(mr == H - 1 && mc == W - 1), 16'(mc - 1), 16'(mr - 1)});
            exp_v_q.push_back(1'b1);
        end else begin
            exp_v_q.push_back(1'b0);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
        pix_in = v;
        sof = s;
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof = 1'b0;
        pix_in = PW'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            sof = 1'($urandom);
            pix_in = PW'($urandom);
            @(posedge clk);
            #1;
        end
        sof = 1'b0;
    endtask

    task automatic do_reset(input bit with_pix);
        rst = 1'b1;
        pix_valid = with_pix;
        sof = with_pix;
        pix_in = PW'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pix_valid = 1'b0;
        sof = 1'b0;
        mr = 0;
        mc = 0;
        tests++;
        if (win_out !== '0 || win_valid !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: win_out=%h win_valid=%b frame_done=%b, required all 0", win_out, win_valid, frame_done);
        end
`ifdef SOBEL_WINDOW_COORD_EN
        tests++;
        if (win_cx !== 16'd0 || win_cy !== 16'd0) begin
            fails++;
            $display("FAIL reset_coord: got (%0d,%0d) required (0,0)", win_cx, win_cy);
        end
`endif
    endtask

    // count pixels from a frame's (0,0); stops after n pixels
    task automatic send_frame(input bit rnd, input int max_gap, input bit s0, input int n);
        int cnt = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (cnt < n) begin
                    send(rnd ? PW'($urandom) : PW'(16 * r + c), s0 && r == 0 && c == 0);
                    if (max_gap > 0) idle($urandom_range(1, max_gap));
                end
                cnt++;
            end
        end
    endtask

    initial begin
        do_reset(1'b0);
        idle(2);
        send_frame(1'b0, 0, 1'b0, W * H);
        idle(3);
        send_frame(1'b0, 5, 1'b0, W * H);
        send_frame(1'b1, 0, 1'b0, W * H);
        send_frame(1'b1, 0, 1'b0, W * H);
        idle(2);
        // abandon a frame at (1,2) with a new sof
        send_frame(1'b1, 0, 1'b0, W + 2);
        send_frame(1'b1, 0, 1'b1, W * H);
        idle(2);
        // reset in the middle of row 2, then a clean frame
        send_frame(1'b0, 0, 1'b0, 2 * W + 3);
        do_reset(1'b1);
        send_frame(1'b0, 0, 1'b0, W * H);
        for (int f = 0; f < 6; f++) begin
            send_frame(1'b1, $urandom_range(0, 3), 1'($urandom), W * H);
        end
        idle(4);
        tests++;
        if (exp_q.size() != 0 || exp_v_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d windows and %0d pixels outstanding, required 0", exp_q.size(), exp_v_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL timeout: bench did not complete within time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
